aes_resp_misr: RTL and testbench

- Response-compaction stage placed directly downstream of aes_128.
- Tracks which cycles launched a valid plaintext/key pair into the AES pipeline. After a fixed pipeline latency, it captures the 128-bit ciphertext from each launch.
- Folds every captured ciphertext into a 128-bit MISR signature and counts completed encryptions.
- Reports done, and pass/fail against an expected signature, for a self-checking stimulus harness.

---
 rtl/aes_resp_misr.sv | 210 +++++++++++++++++++++
 tb/tb_aes_resp_misr.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_resp_misr.sv
// aes_resp_misr
//
// Response-compaction stage that sits directly downstream of aes_128. It
// records which cycles launched a plaintext/key pair into the AES pipeline.
// After the fixed pipeline latency it folds the matching ciphertext into a
// 128-bit MISR signature and counts the completed encryptions. At the end
// of a run it reports done, and pass/fail against a golden signature.
//
// Parameters:
//   WIDTH    ciphertext / signature width (the feedback taps assume 128)
//   LATENCY  cycles from an accepted launch to the matching aes_128 output
//   CNT_W    width of num_tests and of the internal counters
//   SEED     MISR value loaded on start and on reset
//
// Ports:
//   clk, rst_n     clock shared with aes_128; asynchronous active-low reset
//   start          one-cycle pulse that begins a run (ignored while busy)
//   num_tests      number of encryptions in the run, sampled on start
//   launch_valid   a state/key pair is presented to aes_128 this cycle
//   launch_ready   high in RUN while launches remain
//   aes_out        aes_128 ciphertext bus
//   expected_sig   golden signature, sampled when DONE is entered
//   signature      current MISR value
//   capt_count     ciphertexts compacted so far in this run
//   busy           high in RUN or DRAIN
//   done           high in DONE
//   pass           valid while done; 1 when signature matched expected_sig
//
// Optional feature (macro AES_RESP_FIRST_CAPT_EN):
//   first_out      ciphertext of the first capture of the run
//   first_vld      first_out holds a capture from this run
//
// Handshake: a launch is accepted (acc) in any cycle where launch_valid and
// launch_ready are both high at the rising edge. launch_valid while
// launch_ready is low is simply dropped: it is neither counted nor tracked.
// launch_ready does not depend on launch_valid.

module aes_resp_misr #(
    parameter int              WIDTH   = 128,
    parameter int              LATENCY = 21,
    parameter int              CNT_W   = 32,
    parameter logic [WIDTH-1:0] SEED   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_tests,
    input  logic              launch_valid,
    output logic              launch_ready,
    input  logic [WIDTH-1:0]  aes_out,
    input  logic [WIDTH-1:0]  expected_sig,
    output logic [WIDTH-1:0]  signature,
    output logic [CNT_W-1:0]  capt_count,
    output logic              busy,
    output logic              done,
`ifdef AES_RESP_FIRST_CAPT_EN
    output logic [WIDTH-1:0]  first_out,
    output logic              first_vld,
`endif
    output logic              pass
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   sig_q;
    logic [CNT_W-1:0]   capt_q;
    logic [CNT_W-1:0]   launch_cnt_q;
    logic [CNT_W-1:0]   n_q;
    logic [LATENCY-1:0] dly_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
`ifdef AES_RESP_FIRST_CAPT_EN
    logic [WIDTH-1:0]   first_q;
    logic               first_vld_q;
`endif

    logic               acc;
    logic               dv;
    logic               capt_en;
    logic               fb;
    logic [WIDTH-1:0]   misr_next;
    logic [WIDTH-1:0]   sig_next;
    logic [CNT_W-1:0]   capt_next;
    logic [CNT_W-1:0]   launch_next;

    always_comb begin
        acc         = launch_valid & ready_q;
        // Tap at the far end of the delay line lines up with aes_128's output.
        dv          = dly_q[LATENCY-1];
        capt_en     = dv & ((state_q == RUN) || (state_q == DRAIN));
        fb          = sig_q[127] ^ sig_q[125] ^ sig_q[100] ^ sig_q[98];
        misr_next   = {sig_q[WIDTH-2:0], fb} ^ aes_out;
        sig_next    = capt_en ? misr_next : sig_q;
        capt_next   = capt_en ? (capt_q + CNT_W'(1)) : capt_q;
        launch_next = launch_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sig_q        <= SEED;
            capt_q       <= '0;
            launch_cnt_q <= '0;
            n_q          <= '0;
            dly_q        <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
`ifdef AES_RESP_FIRST_CAPT_EN
            first_q      <= '0;
            first_vld_q  <= 1'b0;
`endif
        end else begin
            // The delay line runs in every state; a start below overrides
            // this shift and flushes it.
            dly_q <= {dly_q[LATENCY-2:0], acc};

            // Capture is shared by RUN and DRAIN (capt_en already gated).
            if (capt_en) begin
                sig_q  <= misr_next;
                capt_q <= capt_next;
`ifdef AES_RESP_FIRST_CAPT_EN
                if (!first_vld_q) begin
                    first_q     <= aes_out;
                    first_vld_q <= 1'b1;
                end
`endif
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        sig_q        <= SEED;
                        capt_q       <= '0;
                        launch_cnt_q <= '0;
                        dly_q        <= '0;
`ifdef AES_RESP_FIRST_CAPT_EN
                        first_q      <= '0;
                        first_vld_q  <= 1'b0;
`endif
                        if (num_tests == '0) begin
                            // Empty run: nothing to compact, report at once.
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (SEED == expected_sig);
                        end else begin
                            n_q     <= num_tests;
                            state_q <= RUN;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            pass_q  <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    if (acc) begin
                        launch_cnt_q <= launch_next;
                        if (launch_next == n_q) begin
                            state_q <= DRAIN;
                            ready_q <= 1'b0;
                        end
                    end
                end

                DRAIN: begin
                    // capt_next includes a capture happening this cycle, so
                    // the final ciphertext is already folded into sig_next.
                    if (capt_next == n_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (sig_next == expected_sig);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign launch_ready = ready_q;
    assign signature    = sig_q;
    assign capt_count   = capt_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
`ifdef AES_RESP_FIRST_CAPT_EN
    assign first_out    = first_q;
    assign first_vld    = first_vld_q;
`endif

endmodule

// File: tb/tb_aes_resp_misr.sv
// tb_aes_resp_misr
//
// Directed bench for aes_resp_misr with default parameters (WIDTH=128,
// LATENCY=21, CNT_W=32, SEED=0). A table of single-run vectors is applied
// in a loop; the zero-test, start-while-busy and reset-mid-drain cases are
// hand-written sequences. Inputs change on the falling edge; outputs are
// sampled on the falling edge, away from the active rising edge.

module tb_aes_resp_misr;

    localparam int WIDTH = 128;
    localparam int LAT   = 21;
    localparam int CNT_W = 32;

    localparam logic [127:0] KAT     = 128'h3925841D02DC09FBDC118597196A0B32;
    localparam logic [127:0] NOISE   = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] BIT127  = 128'h80000000_00000000_00000000_00000000;
    localparam logic [127:0] BIT125  = 128'h20000000_00000000_00000000_00000000;
    localparam logic [127:0] BIT100  = 128'h00000010_00000000_00000000_00000000;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  num_tests;
    logic              launch_valid;
    logic              launch_ready;
    logic [WIDTH-1:0]  aes_out;
    logic [WIDTH-1:0]  expected_sig;
    logic [WIDTH-1:0]  signature;
    logic [CNT_W-1:0]  capt_count;
    logic              busy;
    logic              done;
    logic              pass;
`ifdef AES_RESP_FIRST_CAPT_EN
    logic [WIDTH-1:0]  first_out;
    logic              first_vld;
`endif

    always #5 clk = ~clk;

    aes_resp_misr dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_tests    (num_tests),
        .launch_valid (launch_valid),
        .launch_ready (launch_ready),
        .aes_out      (aes_out),
        .expected_sig (expected_sig),
        .signature    (signature),
        .capt_count   (capt_count),
        .busy         (busy),
        .done         (done),
`ifdef AES_RESP_FIRST_CAPT_EN
        .first_out    (first_out),
        .first_vld    (first_vld),
`endif
        .pass         (pass)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int                 n;
        logic [31:0]        mask;      // launch_valid per RUN cycle
        logic [3:0][127:0]  aes;       // ciphertext for k-th accepted launch
        logic [127:0]       exp_in;    // expected_sig driven
        logic [127:0]       exp_sig;   // required final signature
        logic               exp_pass;
        int                 exp_done;  // RUN cycle in which done is first seen
    } vec_t;

    vec_t vecs[7];

    task automatic set_vec(input int i, input int n, input logic [31:0] mask,
                           input logic [127:0] a0, input logic [127:0] a1,
                           input logic [127:0] a2, input logic [127:0] a3,
                           input logic [127:0] exp_in, input logic [127:0] exp_sig,
                           input logic exp_pass, input int exp_done);
        vecs[i].n        = n;
        vecs[i].mask     = mask;
        vecs[i].aes[0]   = a0;
        vecs[i].aes[1]   = a1;
        vecs[i].aes[2]   = a2;
        vecs[i].aes[3]   = a3;
        vecs[i].exp_in   = exp_in;
        vecs[i].exp_sig  = exp_sig;
        vecs[i].exp_pass = exp_pass;
        vecs[i].exp_done = exp_done;
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int n, input logic [127:0] exp_in);
        @(negedge clk);
        start        = 1'b1;
        num_tests    = CNT_W'(n);
        expected_sig = exp_in;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int acc_cyc[4];
        int na;
        int last_acc;
        logic [127:0] drive;
        v  = vecs[idx];
        na = 0;
        for (int c = 0; c < 32; c++)
            if (v.mask[c] && na < v.n) begin
                acc_cyc[na] = c;
                na++;
            end
        last_acc = acc_cyc[na-1];
        exp_q.push_back(v.exp_sig);

        pulse_start(v.n, v.exp_in);
        check($sformatf("v%0d_busy_c0", idx), busy, 1'b1);
        for (int cyc = 0; cyc <= v.exp_done; cyc++) begin
            check($sformatf("v%0d_ready_c%0d", idx, cyc), launch_ready, (cyc <= last_acc));
            check($sformatf("v%0d_done_c%0d", idx, cyc), done, (cyc >= v.exp_done));
            launch_valid = v.mask[cyc];
            drive = NOISE;
            for (int k = 0; k < na; k++)
                if (cyc == acc_cyc[k] + LAT) drive = v.aes[k];
            aes_out = drive;
            @(negedge clk);
        end
        launch_valid = 1'b0;
        aes_out      = NOISE;
        check($sformatf("v%0d_sig", idx), signature, exp_q.pop_front());
        check($sformatf("v%0d_capt", idx), capt_count, 128'(v.n));
        check($sformatf("v%0d_pass", idx), pass, v.exp_pass);
        check($sformatf("v%0d_busy_end", idx), busy, 1'b0);
`ifdef AES_RESP_FIRST_CAPT_EN
        check($sformatf("v%0d_first_vld", idx), first_vld, 1'b1);
        check($sformatf("v%0d_first_out", idx), first_out, v.aes[0]);
`endif
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, done, 1'b1);
    endtask

    // ---------------- test body ----------------
    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        num_tests    = '0;
        launch_valid = 1'b0;
        aes_out      = '0;
        expected_sig = '0;

        //      idx n  mask    a0      a1      a2  a3  exp_in       exp_sig  pass done
        set_vec(0, 1, 32'h1,  KAT,    '0,     '0, '0, KAT,         KAT,     1'b1, 22);
        set_vec(1, 1, 32'h1,  KAT,    '0,     '0, '0, KAT ^ 128'h1, KAT,    1'b0, 22);
        set_vec(2, 4, 32'hF,  '0,     '0,     '0, '0, '0,          '0,      1'b1, 25);
        set_vec(3, 2, 32'h61, 128'h1, 128'h1, '0, '0, 128'h3,      128'h3,  1'b1, 27);
        set_vec(4, 2, 32'h3,  BIT127, '0,     '0, '0, 128'h1,      128'h1,  1'b1, 23);
        set_vec(5, 3, 32'h7,  BIT125, '0,     '0, '0,
                128'h80000000_00000000_00000000_00000002,
                128'h80000000_00000000_00000000_00000002, 1'b1, 24);
        set_vec(6, 3, 32'h7,  BIT100, '0,     '0, '0, '0,
                128'h00000040_00000000_00000000_00000002, 1'b0, 24);

        // Reset values
        #22;
        check("rst_sig", signature, '0);
        check("rst_capt", capt_count, '0);
        check("rst_ready", launch_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Zero tests: DONE the cycle after start, signature reloaded to SEED
        pulse_start(0, '0);
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_sig", signature, '0);
        check("zero_capt", capt_count, '0);
        check("zero_pass", pass, 1'b1);
        pulse_start(0, 128'h1);
        check("zero_pass_bad", pass, 1'b0);

        // Start issued in RUN must not re-latch num_tests
        aes_out = 128'h1;
        pulse_start(2, 128'h3);
        launch_valid = 1'b1;
        @(negedge clk);
        start     = 1'b1;
        num_tests = CNT_W'(5);
        @(negedge clk);
        start = 1'b0;
        check("sir_ready_c2", launch_ready, 1'b0);
        check("sir_busy_c2", busy, 1'b1);
        @(negedge clk);
        launch_valid = 1'b0;
        wait_done("sir_done", 40);
        check("sir_capt", capt_count, 128'h2);
        check("sir_sig", signature, 128'h3);
        check("sir_pass", pass, 1'b1);

        // Reset while draining: immediate clear, in-flight launch discarded
        aes_out = KAT;
        pulse_start(2, '0);
        for (int cyc = 0; cyc < 22; cyc++) begin
            launch_valid = (cyc < 2);
            @(negedge clk);
        end
        launch_valid = 1'b0;
        check("mid_capt", capt_count, 128'h1);
        check("mid_sig", signature, KAT);
        rst_n = 1'b0;
        #1;
        check("arst_sig", signature, '0);
        check("arst_capt", capt_count, '0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_ready", launch_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_capt", capt_count, '0);
        check("post_rst_sig", signature, '0);
        check("post_rst_done", done, 1'b0);
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
